// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counter timer with one-shot and periodic modes
//
// Purpose:
//   Counts a loaded value down to a terminal count, one step per cycle while
//   dec is high.  At terminal count it either reloads the last loaded value
//   (periodic mode) or stops at zero and raises a sticky expired flag
//   (one-shot mode).  A one-cycle tc pulse marks every terminal-count event.
//
// Ports:
//   clk          in   1  single clock, all state updates on the rising edge
//   reset        in   1  synchronous active-high reset, overrides everything
//   load         in   1  load d into the count and reload registers
//   dec          in   1  decrement enable, only effective while running
//   auto_reload  in   1  1 = periodic, 0 = one-shot; sampled at terminal count
//   d            in   N  load value
//   q            out  N  current count (registered)
//   tc           out  1  one-cycle terminal-count pulse (registered)
//   expired      out  1  sticky flag, set when a one-shot run completes
//   busy         out  1  high exactly while the timer is running

module down_timer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic         auto_reload,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         expired,
  output logic         busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [N-1:0] reload_reg;
  logic [N-1:0] reload_nxt;
  logic [N-1:0] q_nxt;
  logic         tc_nxt;
  logic         expired_nxt;

  // Next-state logic.  tc defaults low every cycle so it can only ever be a
  // single-cycle pulse; load is checked first so it wins over dec everywhere.
  always_comb begin
    state_nxt   = state;
    q_nxt       = q;
    reload_nxt  = reload_reg;
    tc_nxt      = 1'b0;
    expired_nxt = expired;

    if (load) begin
      q_nxt       = d;
      reload_nxt  = d;
      expired_nxt = 1'b0;
      // A zero load has nothing to count, so park in IDLE rather than RUN.
      state_nxt   = (d != ZERO) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (dec) begin
            if (q > ONE) begin
              q_nxt = q - ONE;
            end else begin
              // Terminal count: q is 1 here (RUN is never entered with 0 and
              // reload_reg is nonzero whenever RUN is active).
              tc_nxt = 1'b1;
              if (auto_reload) begin
                q_nxt = reload_reg;
              end else begin
                q_nxt       = ZERO;
                state_nxt   = EXPIRED;
                expired_nxt = 1'b1;
              end
            end
          end
        end
        IDLE, EXPIRED: begin
          // dec is ignored outside RUN; q stays at its value (zero).
        end
        default: begin
          // Unused encoding: recover to a clean idle state.
          state_nxt   = IDLE;
          q_nxt       = ZERO;
          expired_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
      expired    <= expired_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - self-checking bench for down_timer

module tb_down_timer;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic         dec = 1'b0;
  logic         auto_reload = 1'b0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q;
  logic         tc;
  logic         expired;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  down_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .dec         (dec),
    .auto_reload (auto_reload),
    .d           (d),
    .q           (q),
    .tc          (tc),
    .expired     (expired),
    .busy        (busy)
  );

  typedef struct {
    logic         r;
    logic         l;
    logic         de;
    logic         ar;
    logic [N-1:0] dd;
    logic [N-1:0] eq;
    logic         etc;
    logic         eexp;
    logic         ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, l, de, ar, input logic [N-1:0] dd,
                     input logic [N-1:0] eq, input logic etc, eexp, ebusy);
    vec_t v;
    v.r = r; v.l = l; v.de = de; v.ar = ar; v.dd = dd;
    v.eq = eq; v.etc = etc; v.eexp = eexp; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input logic r, l, de, ar, input logic [N-1:0] dd);
    @(negedge clk);
    reset = r; load = l; dec = de; auto_reload = ar; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] eq,
                            input logic etc, eexp, ebusy);
    chk({tag, " q"}, q, eq);
    chk({tag, " tc"}, N'(tc), N'(etc));
    chk({tag, " expired"}, N'(expired), N'(eexp));
    chk({tag, " busy"}, N'(busy), N'(ebusy));
  endtask

  // Reference model state: plain count / reload value / running flag.
  logic [N-1:0] m_cnt, m_rl;
  logic         m_run, m_tc, m_exp;

  task automatic model(input logic r, l, de, ar, input logic [N-1:0] dd);
    m_tc = 1'b0;
    if (r) begin
      m_cnt = 0; m_rl = 0; m_run = 0; m_exp = 0;
    end else if (l) begin
      m_cnt = dd; m_rl = dd; m_exp = 0; m_run = (dd != 0);
    end else if (m_run && de) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_tc = 1'b1;
        if (ar) m_cnt = m_rl;
        else begin
          m_cnt = 0; m_run = 0; m_exp = 1;
        end
      end
    end
  endtask

  initial begin
    // r  l  de ar  d         q         tc exp busy
    add(1, 1, 1, 0, 16'h0055, 16'h0000, 0, 0, 0);  // reset beats load
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);  // dec in IDLE ignored
    add(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
    // one-shot run from 3
    add(0, 1, 1, 0, 16'h0003, 16'h0003, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);  // dec in EXPIRED: no wrap
    add(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    // periodic run from 2, dec high for 6 cycles including the load cycle
    add(0, 1, 1, 1, 16'h0002, 16'h0002, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0002, 1, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0002, 1, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 1);  // hold
    add(0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1);
    // load beats dec in RUN
    add(0, 1, 0, 0, 16'h1234, 16'h1234, 0, 0, 1);
    add(0, 1, 1, 0, 16'h5678, 16'h5678, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h5677, 0, 0, 1);
    // load zero parks in IDLE
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
    // periodic with reload 1: tc after every effective dec
    add(0, 1, 0, 1, 16'h0001, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 1);
    add(0, 1, 0, 1, 16'h0007, 16'h0007, 0, 0, 1);  // load right after tc clears it
    // auto_reload sampled only at the terminal edge
    add(0, 1, 0, 1, 16'h0002, 16'h0002, 0, 0, 1);
    add(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1, 0);
    add(0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1);  // load clears expired

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].l, vecs[i].de, vecs[i].ar, vecs[i].dd);
      check_outs($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc, vecs[i].eexp, vecs[i].ebusy);
    end

    // Reset in RUN at q=1 with dec high: no tc, count aborted, stays IDLE.
    step(0, 1, 0, 0, 16'h0002); check_outs("rst_run load", 16'h0002, 0, 0, 1);
    step(0, 0, 1, 0, 16'h0000); check_outs("rst_run dec", 16'h0001, 0, 0, 1);
    step(1, 0, 1, 0, 16'h0000); check_outs("rst_run reset", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0000); check_outs("rst_run after1", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 1, 16'h0000); check_outs("rst_run after2", 16'h0000, 0, 0, 0);

    // Load of zero in the cycle after a one-shot terminal count.
    step(0, 1, 0, 0, 16'h0001); check_outs("tc_load0 load", 16'h0001, 0, 0, 1);
    step(0, 0, 1, 0, 16'h0000); check_outs("tc_load0 tc", 16'h0000, 1, 1, 0);
    step(0, 1, 1, 0, 16'h0000); check_outs("tc_load0 clr", 16'h0000, 0, 0, 0);

    // Randomized run against the reference model.
    step(1, 0, 0, 0, 16'h0000);
    model(1, 0, 0, 0, 16'h0000);
    check_outs("rand reset", m_cnt, m_tc, m_exp, m_run);
    for (int i = 0; i < 600; i++) begin
      logic r, l, de, ar;
      logic [N-1:0] dd;
      r  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 9) == 0);
      de = ($urandom_range(0, 3) != 0);
      ar = ($urandom_range(0, 2) != 0);
      dd = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom_range(0, 5));
      step(r, l, de, ar, dd);
      model(r, l, de, ar, dd);
      check_outs($sformatf("rand%0d", i), m_cnt, m_tc, m_exp, m_run);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
